mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/mem_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states, access size codes,
// the default IO window base and the size-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // IO window is selected by addr[17:16] == 2'b11.
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_B:  n = 3'd1;
      SIZE_H:  n = 3'd2;
      SIZE_W:  n = 3'd4;
      default: n = 3'd4;  // reserved encoding behaves as a word
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Shares one 8-bit RAM port between instruction fetch and the MEM stage (MEM has priority).
// Define IO_STALL_EN to hold IO-window stores off while the UART FIFO reports full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
`ifdef IO_STALL_EN
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
`endif
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
`ifdef IO_STALL_EN
  input  logic              io_buffer_full,
`endif
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              stall_req_mem,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              is_if_q, is_if_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic              io_block;
  logic              start;
  logic [2:0]        cnt_inc;
  logic [1:0]        lane;
  logic [31:0]       lane_buf;
  logic [ADDR_W-1:0] next_addr;

`ifdef IO_STALL_EN
  // A blocked IO store also blocks fetch so IO side effects stay in program order.
  assign io_block = mem_req & mem_we & (mem_addr[17:16] == IO_BASE[17:16]) & io_buffer_full;
`else
  assign io_block = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    is_if_d     = is_if_q;
    we_d        = we_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    start       = 1'b0;

    cnt_inc   = cnt_q + 3'd1;
    next_addr = base_q + ADDR_W'(cnt_inc);
    // Byte returned now belongs to the address issued one cycle earlier.
    lane      = cnt_q[1:0] - 2'd1;
    lane_buf  = buf_q;
    lane_buf[{lane, 3'b000} +: 8] = ram_din;

    unique case (state_q)
      StIdle: begin
        if (mem_req && !io_block) begin
          start   = 1'b1;
          is_if_d = 1'b0;
          we_d    = mem_we;
          n_d     = size_bytes(mem_size);
          base_d  = mem_addr;
          wdata_d = mem_wdata;
        end else if (if_req && !io_block) begin
          start   = 1'b1;
          is_if_d = 1'b1;
          we_d    = 1'b0;
          n_d     = 3'd4;
          base_d  = if_addr;
        end
        if (start) begin
          cnt_d   = 3'd0;
          buf_d   = 32'd0;
          ram_a_d = base_d;
          if (we_d) begin
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = 1'b1;
            state_d    = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (is_if_q && !if_req) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) buf_d = lane_buf;
          if (cnt_q == n_q) begin
            state_d = StDone;
            cnt_d   = 3'd0;
            if (is_if_q) begin
              if_done_d = 1'b1;
              if_inst_d = lane_buf;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = lane_buf;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < n_q) ram_a_d = next_addr;
          end
        end
      end
      StWr: begin
        if (cnt_q == n_q - 3'd1) begin
          ram_wr_d   = 1'b0;
          mem_done_d = 1'b1;
          cnt_d      = 3'd0;
          state_d    = StDone;
        end else begin
          cnt_d      = cnt_inc;
          ram_a_d    = next_addr;
          ram_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
        end
      end
      StDone: begin
        // First cycle carries the done pulse; the second lets the requester drop its request.
        if (!(if_done_q || mem_done_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      is_if_q     <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      is_if_q     <= is_if_d;
      we_q        <= we_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_a         = ram_a_q;
  assign ram_dout      = ram_dout_q;
  assign ram_wr        = ram_wr_q;
  assign if_done       = if_done_q;
  assign if_inst       = if_inst_q;
  assign mem_done      = mem_done_q;
  assign mem_rdata     = mem_rdata_q;
  assign stall_req_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-addressed reference memory predicts load data and
// done timing; a monitor process pops expectations whenever a done pulse appears.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        stall_req_mem;
  logic [7:0]  ram_din = 8'd0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
`ifdef IO_STALL_EN
    .io_buffer_full(io_buffer_full),
`endif
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_done       (if_done),
    .if_inst       (if_inst),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_size      (mem_size),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_done      (mem_done),
    .mem_rdata     (mem_rdata),
    .stall_req_mem (stall_req_mem),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .ram_a         (ram_a),
    .ram_wr        (ram_wr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [31:0] data;
    int unsigned cyc;
    int unsigned nwr;
  } exp_t;
  exp_t exp_q[$];

  // Unwritten bytes read back a pattern derived from the address bits the RAM model keeps.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ {a[17:16], 5'b0, a[31]} ^ 8'h5A;
  endfunction

  function automatic logic [18:0] ridx(input logic [31:0] a);
    return {a[31], a[17:0]};
  endfunction

  // RAM device: one-cycle read latency, stalls together with the rest of the system on rdy.
  bit         ram_vld [0:524287];
  logic [7:0] ram_mem [0:524287];
  always @(posedge clk) begin
    if (rdy) begin
      if (ram_wr) begin
        ram_mem[ridx(ram_a)] <= ram_dout;
        ram_vld[ridx(ram_a)] <= 1'b1;
      end
      ram_din <= ram_vld[ridx(ram_a)] ? ram_mem[ridx(ram_a)] : init_byte(ram_a);
    end
  end

  // Reference memory for predictions.
  logic [7:0] ref_mem[logic [31:0]];

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // t is the cycle in which the controller samples the request in its idle state.
  task automatic push_exp(input bit is_if, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned t);
    exp_t e;
    int n;
    n = is_if ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.is_if = is_if;
    e.we    = we;
    e.data  = 32'd0;
    for (int k = 0; k < n; k++) begin
      if (we) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
      else    e.data[8*k +: 8] = ref_rd(addr + 32'(k));
    end
    e.cyc = t + n + (we ? 1 : 2);
    e.nwr = we ? n : 0;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input bit want_if);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = want_if ? if_done : mem_done;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no %s done, expected one within 40 cycles",
               want_if ? "if" : "mem");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op(input bit is_if, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    push_exp(is_if, we, size, addr, wdata, cyc);
    if (is_if) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      mem_req   = 1'b1;
      mem_we    = we;
      mem_size  = size;
      mem_addr  = addr;
      mem_wdata = wdata;
    end
    wait_done(is_if);
    if_req  = 1'b0;
    mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  int unsigned wr_cnt = 0;
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_cnt = 0;
      end else begin
        if (ram_wr && rdy) wr_cnt++;
        if (if_done || mem_done) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got if_done=%b mem_done=%b, expected none",
                     if_done, mem_done);
          end else begin
            e = exp_q.pop_front();
            check("done_kind", {31'd0, if_done}, {31'd0, e.is_if});
            check("done_both", {31'd0, if_done & mem_done}, 32'd0);
            check("done_cycle", cyc, e.cyc);
            check("wr_strobes", wr_cnt, e.nwr);
            if (!e.we) check("read_data", e.is_if ? if_inst : mem_rdata, e.data);
            if (!e.is_if) check("stall_at_done", {31'd0, stall_req_mem}, 32'd0);
          end
          wr_cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned t;
    logic [31:0] a;
    int unsigned r;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ram_a", ram_a, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_mem_done", {31'd0, mem_done}, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_stall", {31'd0, stall_req_mem}, 32'd0);
    @(posedge clk); #1;

    // Preload 13,00,00,93 at 0x1000 and fetch it back as an instruction word.
    do_op(1'b0, 1'b1, 2'd2, 32'h0000_1000, 32'h9300_0013);
    do_op(1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'd0);
    check("if_word_value", if_inst, 32'h9300_0013);

    // MEM byte store and IF fetch arrive together: MEM first, IF accepted 4 cycles later.
    t = cyc;
    push_exp(1'b0, 1'b1, 2'd0, 32'h0000_0020, 32'h0000_00AB, t);
    push_exp(1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'd0, t + 4);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h20; mem_wdata = 32'hAB;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    repeat (2) @(negedge clk);
    check("prio_ram_a", ram_a, 32'h0000_0020);
    check("prio_ram_dout", {24'd0, ram_dout}, 32'h0000_00AB);
    check("prio_ram_wr", {31'd0, ram_wr}, 32'd1);
    check("prio_stall", {31'd0, stall_req_mem}, 32'd1);
    wait_done(1'b0);
    mem_req = 1'b0;
    wait_done(1'b1);
    if_req = 1'b0;
    @(posedge clk); #1;

    // Half load straddling the top of the address space.
    do_op(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0);
    check("wrap_half", mem_rdata, {16'd0, init_byte(32'h0), init_byte(32'hFFFF_FFFF)});

    // Fetch abandoned at T+2, then a load accepted at T+3.
    t = cyc;
    if_req = 1'b1; if_addr = 32'h0000_0104;
    repeat (2) begin @(posedge clk); #1; end
    if_req = 1'b0;
    @(posedge clk); #1;
    push_exp(1'b0, 1'b0, 2'd0, 32'h0000_0104, 32'd0, t + 3);
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h0000_0104;
    wait_done(1'b0);
    mem_req = 1'b0;
    @(posedge clk); #1;

    // rdy low for three cycles in the middle of a word fetch.
    t = cyc;
    push_exp(1'b1, 1'b0, 2'd2, 32'h0000_0108, 32'd0, t + 3);
    if_req = 1'b1; if_addr = 32'h0000_0108;
    repeat (2) begin @(posedge clk); #1; end
    rdy = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("freeze_ram_a", ram_a, 32'h0000_0109);
    check("freeze_if_done", {31'd0, if_done}, 32'd0);
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_done(1'b1);
    if_req = 1'b0;
    @(posedge clk); #1;

    // Reset pulse at T+2 of a word store to an address that is never read back.
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h0000_8000;
    mem_wdata = 32'hDEAD_BEEF;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
    check("mid_rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("mid_rst_ram_a", ram_a, 32'd0);
    check("mid_rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check("mid_rst_if_inst", if_inst, 32'd0);
    check("mid_rst_mem_rdata", mem_rdata, 32'd0);
    check("mid_rst_mem_done", {31'd0, mem_done}, 32'd0);
    repeat (2) begin @(posedge clk); #1; end

`ifdef IO_STALL_EN
    // IO store held off by a full FIFO; the pending fetch must wait behind it.
    t = cyc;
    io_buffer_full = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h0003_0000;
    mem_wdata = 32'h0000_0055;
    if_req = 1'b1; if_addr = 32'h0000_010C;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    check("io_blocked_wr", {31'd0, ram_wr}, 32'd0);
    check("io_blocked_stall", {31'd0, stall_req_mem}, 32'd1);
    @(posedge clk); #1;
    io_buffer_full = 1'b0;
    push_exp(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0055, t + 5);
    push_exp(1'b1, 1'b0, 2'd2, 32'h0000_010C, 32'd0, t + 9);
    wait_done(1'b0);
    mem_req = 1'b0;
    wait_done(1'b1);
    if_req = 1'b0;
    @(posedge clk); #1;
`endif

    // Random mix over three small regions, one of them wrapping past 0xFFFF_FFFF.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 2);
      a = (r == 0) ? 32'h0000_0100 : (r == 1) ? 32'hFFFF_FFF8 : 32'h0003_0000;
      a = a + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) do_op(1'b1, 1'b0, 2'd2, a, 32'd0);
      else do_op(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
    end

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
